// File: rtl/net_resolver_pkg.sv
// Shared types and helpers for the multi-driver net resolver: four-state
// encoding, net-type modes and per-column driver flag extraction.
package net_resolver_pkg;

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LZ = 2'b10,
    LX = 2'b11
  } nr_logic4_e;

  typedef enum logic [2:0] {
    NR_WIRE   = 3'd0,
    NR_TRI0   = 3'd1,
    NR_TRI1   = 3'd2,
    NR_WAND   = 3'd3,
    NR_WOR    = 3'd4,
    NR_TRIREG = 3'd5
  } nr_mode_e;

  // tri, triand and trior resolve exactly like wire, wand and wor.
  localparam nr_mode_e NR_TRI    = NR_WIRE;
  localparam nr_mode_e NR_TRIAND = NR_WAND;
  localparam nr_mode_e NR_TRIOR  = NR_WOR;

  localparam int NR_MAX_DRV = 16;

  typedef struct packed {
    logic has0;
    logic has1;
    logic hasx;
    logic allz;
  } nr_flags_t;

  function automatic nr_flags_t nr_flags(input logic [2*NR_MAX_DRV-1:0] col,
                                         input int unsigned ndrv);
    nr_flags_t f;
    f.has0 = 1'b0;
    f.has1 = 1'b0;
    f.hasx = 1'b0;
    f.allz = 1'b1;
    for (int unsigned i = 0; i < NR_MAX_DRV; i++) begin
      if (i < ndrv) begin
        case (nr_logic4_e'(col[2*i +: 2]))
          L0: begin
            f.has0 = 1'b1;
            f.allz = 1'b0;
          end
          L1: begin
            f.has1 = 1'b1;
            f.allz = 1'b0;
          end
          LX: begin
            f.hasx = 1'b1;
            f.allz = 1'b0;
          end
          default: begin
            f.allz = f.allz;
          end
        endcase
      end else begin
        f.allz = f.allz;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/net_resolver_bit.sv
// Combinational resolution of one net bit from NDRV four-state drivers
// under a fixed net-type rule; also reports all-z and 0/1 contention.
module net_resolve_bit
  import net_resolver_pkg::*;
#(
  parameter int       NDRV = 2,
  parameter nr_mode_e MODE = NR_WIRE
) (
  input  logic [2*NDRV-1:0] drv_i,
  output logic [1:0]        val_o,
  output logic              allz_o,
  output logic              contended_o
);

  logic [2*NR_MAX_DRV-1:0] col_s;
  nr_flags_t               flags_s;
  logic [1:0]              wire_s;

  // Column padding and flag extraction.
  always_comb begin
    col_s = {(2*NR_MAX_DRV){1'b0}};
    col_s[2*NDRV-1:0] = drv_i;
    flags_s = nr_flags(col_s, NDRV);
  end

  // Rule selection; trireg shares the wire rule and its charge lives upstream.
  always_comb begin
    if (flags_s.allz) begin
      wire_s = LZ;
    end else if (flags_s.hasx || (flags_s.has0 && flags_s.has1)) begin
      wire_s = LX;
    end else if (flags_s.has0) begin
      wire_s = L0;
    end else begin
      wire_s = L1;
    end

    val_o = wire_s;
    case (MODE)
      NR_TRI0: begin
        if (flags_s.allz) val_o = L0;
        else              val_o = wire_s;
      end
      NR_TRI1: begin
        if (flags_s.allz) val_o = L1;
        else              val_o = wire_s;
      end
      NR_WAND: begin
        if (flags_s.has0)      val_o = L0;
        else if (flags_s.hasx) val_o = LX;
        else if (flags_s.has1) val_o = L1;
        else                   val_o = LZ;
      end
      NR_WOR: begin
        if (flags_s.has1)      val_o = L1;
        else if (flags_s.hasx) val_o = LX;
        else if (flags_s.has0) val_o = L0;
        else                   val_o = LZ;
      end
      default: begin
        val_o = wire_s;
      end
    endcase

    allz_o      = flags_s.allz;
    contended_o = flags_s.has0 && flags_s.has1 &&
                  (MODE != NR_WAND) && (MODE != NR_WOR);
  end

endmodule

// File: rtl/net_resolver.sv
// Registered multi-driver net resolver: per-bit resolution, trireg charge
// storage with sample-counted decay, and a saturating contention counter.
module net_resolver
  import net_resolver_pkg::*;
#(
  parameter int       WIDTH        = 8,
  parameter int       NDRV         = 2,
  parameter nr_mode_e MODE         = NR_WIRE,
  parameter int       DECAY_CYCLES = 4,
  parameter int       CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NDRV*WIDTH*2-1:0]  drv_val,
  input  logic [NDRV-1:0]          drv_en,
  input  logic                     cont_clr,
  output logic                     out_valid,
  output logic [WIDTH*2-1:0]       out_val,
  output logic                     contention,
  output logic [CNT_W-1:0]         cont_count
);

  // Decay counter must reach DECAY_CYCLES+1 so a decayed bit stays decayed.
  localparam int              DW        = (DECAY_CYCLES < 1) ? 1 : $clog2(DECAY_CYCLES + 2);
  localparam logic [DW-1:0]   DECAY_LIM = DW'(DECAY_CYCLES);
  localparam logic [DW-1:0]   DECAY_MAX = {DW{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0][1:0]    res_s;
  logic [WIDTH-1:0]         allz_s;
  logic [WIDTH-1:0]         cont_s;

  logic                     out_valid_q;
  logic [WIDTH-1:0][1:0]    out_val_q, out_val_d;
  logic [WIDTH-1:0][1:0]    charge_q, charge_d;
  logic [WIDTH-1:0][DW-1:0] decay_q, decay_d;
  logic                     contention_q, contention_d;
  logic [CNT_W-1:0]         cont_count_q, cont_count_d;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [2*NDRV-1:0] col_s;

    // Gather this bit's column; a disabled driver presents z.
    always_comb begin
      col_s = {(2*NDRV){1'b0}};
      for (int d = 0; d < NDRV; d++) begin
        if (drv_en[d]) col_s[2*d +: 2] = drv_val[(d*WIDTH+b)*2 +: 2];
        else           col_s[2*d +: 2] = LZ;
      end
    end

    net_resolve_bit #(
      .NDRV (NDRV),
      .MODE (MODE)
    ) u_bit (
      .drv_i       (col_s),
      .val_o       (res_s[b]),
      .allz_o      (allz_s[b]),
      .contended_o (cont_s[b])
    );
  end

  // Next-state for resolved value, trireg charge/decay and contention.
  always_comb begin
    out_val_d    = out_val_q;
    charge_d     = charge_q;
    decay_d      = decay_q;
    contention_d = contention_q;
    if (in_valid) begin
      contention_d = |cont_s;
      for (int b = 0; b < WIDTH; b++) begin
        if (MODE == NR_TRIREG) begin
          if (!allz_s[b]) begin
            out_val_d[b] = res_s[b];
            charge_d[b]  = res_s[b];
            decay_d[b]   = {DW{1'b0}};
          end else begin
            if (decay_q[b] != DECAY_MAX) decay_d[b] = decay_q[b] + DW'(1'b1);
            else                         decay_d[b] = decay_q[b];
            if ((DECAY_CYCLES == 0) || (decay_d[b] <= DECAY_LIM)) out_val_d[b] = charge_q[b];
            else                                                   out_val_d[b] = LX;
          end
        end else begin
          out_val_d[b] = res_s[b];
        end
      end
    end else begin
      contention_d = contention_q;
    end
  end

  // Saturating contention counter; clear has priority.
  always_comb begin
    cont_count_d = cont_count_q;
    if (cont_clr) begin
      cont_count_d = {CNT_W{1'b0}};
    end else if (in_valid && (|cont_s) && (cont_count_q != CNT_MAX)) begin
      cont_count_d = cont_count_q + CNT_W'(1'b1);
    end else begin
      cont_count_d = cont_count_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_val_q    <= {WIDTH{2'b10}};
      charge_q     <= {WIDTH{2'b11}};
      decay_q      <= {(WIDTH*DW){1'b0}};
      contention_q <= 1'b0;
      cont_count_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q  <= in_valid;
      out_val_q    <= out_val_d;
      charge_q     <= charge_d;
      decay_q      <= decay_d;
      contention_q <= contention_d;
      cont_count_q <= cont_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_val    = out_val_q;
  assign contention = contention_q;
  assign cont_count = cont_count_q;

endmodule
